// File: rtl/mux_n_para1_registrado.sv
// N-to-1 bus multiplexer with a registered output stage and a valid/ready handshake.
// Captures a manually selected channel on request, or scans all channels round-robin.
module mux_n_para1_registrado #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  load,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  frame_done,
  output logic                  sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

  logic             w_can_load;
  logic             w_cap_scan;
  logic             w_cap_man;
  logic             w_sel_oor;
  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_ch_data;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_chan;
  logic             r_frame_done;
  logic             r_sel_err;
  logic [SEL_W-1:0] r_ptr;

  // Single output stage: a new sample may enter only if the slot is empty or being drained.
  assign w_can_load = !r_valid || out_ready;
  assign w_cap_scan = w_can_load && mode;
  assign w_cap_man  = w_can_load && !mode && load;
  assign w_idx      = mode ? r_ptr : sel;

  // Out-of-range selects exist only when N_IN leaves unused codes in the select field.
  if ((1 << SEL_W) == N_IN) begin : g_sel_full
    assign w_sel_oor = 1'b0;
  end else begin : g_sel_partial
    assign w_sel_oor = (sel >= SEL_W'(N_IN));
  end

  // An index that matches no channel falls through to the all-zeros default.
  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (w_idx == SEL_W'(k)) w_ch_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is asynchronous and discards any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_chan       <= '0;
      r_frame_done <= 1'b0;
      r_sel_err    <= 1'b0;
      r_ptr        <= '0;
    end else begin
      r_frame_done <= w_cap_scan && (r_ptr == LAST_CH);

      if (w_cap_scan || w_cap_man) begin
        r_data  <= w_ch_data;
        r_chan  <= w_idx;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_cap_man && w_sel_oor) r_sel_err <= 1'b1;

      if (!mode) begin
        r_ptr <= '0;
      end else if (w_cap_scan) begin
        r_ptr <= (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_chan   = r_chan;
  assign frame_done = r_frame_done;
  assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_mux_n_para1_registrado.sv
// Directed bench for mux_n_para1_registrado: a 4-channel instance driven from a vector
// table, and a 3-channel instance exercising out-of-range selects and scan wrap.
module tb_mux_n_para1_registrado;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0] a_bus   = 32'h44332211;
  logic [1:0]  a_sel   = '0;
  logic        a_mode  = 1'b0;
  logic        a_load  = 1'b0;
  logic        a_rdy   = 1'b0;
  logic [7:0]  a_data;
  logic        a_valid;
  logic [1:0]  a_chan;
  logic        a_fd;
  logic        a_err;

  // 3-channel instance
  logic [23:0] b_bus   = 24'hC3B2A1;
  logic [1:0]  b_sel   = '0;
  logic        b_mode  = 1'b0;
  logic        b_load  = 1'b0;
  logic        b_rdy   = 1'b0;
  logic [7:0]  b_data;
  logic        b_valid;
  logic [1:0]  b_chan;
  logic        b_fd;
  logic        b_err;

  mux_n_para1_registrado #(.WIDTH(8), .N_IN(4)) dut4 (
    .clk(clk), .rst(rst), .in_bus(a_bus), .sel(a_sel), .mode(a_mode), .load(a_load),
    .out_ready(a_rdy), .out_data(a_data), .out_valid(a_valid), .out_chan(a_chan),
    .frame_done(a_fd), .sel_err(a_err)
  );

  mux_n_para1_registrado #(.WIDTH(8), .N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .in_bus(b_bus), .sel(b_sel), .mode(b_mode), .load(b_load),
    .out_ready(b_rdy), .out_data(b_data), .out_valid(b_valid), .out_chan(b_chan),
    .frame_done(b_fd), .sel_err(b_err)
  );

  typedef struct {
    logic        mode;
    logic        load;
    logic [1:0]  sel;
    logic        rdy;
    logic [31:0] bus;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ec;
    logic        efd;
    logic        chk_dc;   // compare data/chan only when a sample is defined
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  localparam logic [31:0] BUS  = 32'h44332211;
  localparam logic [31:0] BUSX = 32'h443322AA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic m, input logic l, input logic [1:0] s, input logic r,
                     input logic [31:0] bus, input logic ev, input logic [7:0] ed,
                     input logic [1:0] ec, input logic efd, input logic dc);
    vec_t v;
    v.mode = m; v.load = l; v.sel = s; v.rdy = r; v.bus = bus;
    v.ev = ev; v.ed = ed; v.ec = ec; v.efd = efd; v.chk_dc = dc;
    vecs.push_back(v);
  endtask

  initial begin
    // Manual mode: capture, drain, ignored load during a stall
    add(0, 1, 2, 1, BUS,  1, 8'h33, 2, 0, 1);
    add(0, 0, 0, 1, BUS,  0, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, BUS,  1, 8'h22, 1, 0, 1);
    add(0, 1, 3, 0, BUS,  1, 8'h22, 1, 0, 1);
    add(0, 0, 0, 1, BUS,  0, 8'h00, 0, 0, 0);
    // Scan, 9 cycles at full throughput
    add(1, 0, 0, 1, BUS,  1, 8'h11, 0, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h33, 2, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h44, 3, 1, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h11, 0, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h33, 2, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h44, 3, 1, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h11, 0, 0, 1);
    // Stall on channel 1 while its input changes, then resume without skipping
    add(1, 0, 0, 1, BUS,  1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 0, BUSX, 1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 0, BUSX, 1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 0, BUSX, 1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 1, BUSX, 1, 8'h33, 2, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h44, 3, 1, 1);
    // Stall right after the last channel: frame_done must not repeat
    add(1, 0, 0, 0, BUS,  1, 8'h44, 3, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h11, 0, 0, 1);
    add(1, 1, 3, 1, BUS,  1, 8'h22, 1, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h33, 2, 0, 1);
    // One manual cycle without load restarts the scan at channel 0
    add(0, 0, 0, 1, BUS,  0, 8'h00, 0, 0, 0);
    add(1, 0, 0, 1, BUS,  1, 8'h11, 0, 0, 1);
    add(1, 0, 0, 1, BUS,  1, 8'h22, 1, 0, 1);

    // Reset state, asserted with no clock edge in between
    #2 rst = 1'b1;
    #1;
    check("reset data", 32'(a_data), 32'h0);
    check("reset valid", 32'(a_valid), 32'h0);
    check("reset chan", 32'(a_chan), 32'h0);
    check("reset fd", 32'(a_fd), 32'h0);
    check("reset err", 32'(a_err), 32'h0);
    tick();
    rst = 1'b0;

    // 3-channel instance: out-of-range select, sticky error, scan wrap at channel 2
    b_rdy = 1'b1; b_load = 1'b1; b_sel = 2'd3;
    tick();
    check("n3 oor data", 32'(b_data), 32'h0);
    check("n3 oor chan", 32'(b_chan), 32'h3);
    check("n3 oor valid", 32'(b_valid), 32'h1);
    check("n3 oor err", 32'(b_err), 32'h1);
    b_sel = 2'd0;
    tick();
    check("n3 sel0 data", 32'(b_data), 32'hA1);
    check("n3 sel0 chan", 32'(b_chan), 32'h0);
    check("n3 sticky err", 32'(b_err), 32'h1);
    b_load = 1'b0; b_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("n3 scan%0d chan", i), 32'(b_chan), 32'(i % 3));
      check($sformatf("n3 scan%0d data", i), 32'(b_data), (i % 3 == 0) ? 32'hA1 : (i % 3 == 1) ? 32'hB2 : 32'hC3);
      check($sformatf("n3 scan%0d fd", i), 32'(b_fd), (i == 2) ? 32'h1 : 32'h0);
    end
    b_mode = 1'b0;
    check("n3 err held", 32'(b_err), 32'h1);

    // Table-driven run on the 4-channel instance
    for (int i = 0; i < vecs.size(); i++) begin
      a_mode = vecs[i].mode;
      a_load = vecs[i].load;
      a_sel  = vecs[i].sel;
      a_rdy  = vecs[i].rdy;
      a_bus  = vecs[i].bus;
      tick();
      check($sformatf("v%0d valid", i), 32'(a_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d fd", i), 32'(a_fd), 32'(vecs[i].efd));
      check($sformatf("v%0d err", i), 32'(a_err), 32'h0);
      if (vecs[i].chk_dc) begin
        check($sformatf("v%0d data", i), 32'(a_data), 32'(vecs[i].ed));
        check($sformatf("v%0d chan", i), 32'(a_chan), 32'(vecs[i].ec));
      end
    end

    // Reset mid-scan with a sample held: clears immediately, including sticky error
    a_rdy = 1'b0;
    tick();
    check("pre-rst valid", 32'(a_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midscan rst data", 32'(a_data), 32'h0);
    check("midscan rst valid", 32'(a_valid), 32'h0);
    check("midscan rst chan", 32'(a_chan), 32'h0);
    check("midscan rst err n3", 32'(b_err), 32'h0);
    tick();
    rst = 1'b0;
    a_rdy = 1'b1;
    tick();
    check("post-rst first chan", 32'(a_chan), 32'h0);
    check("post-rst first data", 32'(a_data), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
